// File: rtl/dffram_128x32.sv
// Single-port flip-flop RAM, BANKS x 16 words of WSIZE bytes, per-byte write enables.
// Registered read output with read-old-data on a same-address write; only Do0 is reset.
module dffram_128x32 #(
  parameter int unsigned WSIZE  = 4,
  parameter int unsigned BANKS  = 8,
  parameter int unsigned AWIDTH = $clog2(BANKS) + 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN0,
  input  logic [WSIZE-1:0]     WE0,
  input  logic [AWIDTH-1:0]    A0,
  input  logic [WSIZE*8-1:0]   Di0,
  output logic [WSIZE*8-1:0]   Do0
);

  localparam int unsigned DW = WSIZE * 8;
  localparam int unsigned BW = $clog2(BANKS);

  logic [BW-1:0]    bank_idx;
  logic [3:0]       word_idx;
  logic [BANKS-1:0] bank_sel;
  logic [DW-1:0]    bank_rdata [BANKS];
  logic [DW-1:0]    do_d, do_q;

  assign bank_idx = A0[AWIDTH-1:4];
  assign word_idx = A0[3:0];

  always_comb begin
    bank_sel = '0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      bank_sel[b] = EN0 && (bank_idx == BW'(b));
    end
  end

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    logic [DW-1:0] mem_q [16];

    // Storage is intentionally not reset; contents are undefined until written.
    always_ff @(posedge CLK) begin
      if (bank_sel[g]) begin
        for (int unsigned i = 0; i < WSIZE; i++) begin
          if (WE0[i]) mem_q[word_idx][8*i +: 8] <= Di0[8*i +: 8];
        end
      end
    end

    assign bank_rdata[g] = mem_q[word_idx];
  end

  // Array is read before the write lands, so a same-address write returns old data.
  always_comb begin
    do_d = do_q;
    if (EN0) do_d = bank_rdata[bank_idx];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      do_q <= '0;
    end else begin
      do_q <= do_d;
    end
  end

  assign Do0 = do_q;

endmodule

// File: tb/tb_dffram_128x32.sv
// Self-checking bench for dffram_128x32: directed scenarios plus random traffic
// checked against a byte-granular array model that tracks which bytes are defined.
module tb_dffram_128x32;

  logic        CLK;
  logic        RST_N;
  logic        EN0;
  logic [3:0]  WE0;
  logic [6:0]  A0;
  logic [31:0] Di0;
  logic [31:0] Do0;

  int unsigned n_cmp;
  int unsigned n_err;

  // Reference model: word array plus per-byte "written" flags.
  logic [31:0] ref_mem [128];
  logic [3:0]  ref_kn  [128];
  logic [31:0] exp_do;
  logic [3:0]  exp_kn;

  dffram_128x32 u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN0   (EN0),
    .WE0   (WE0),
    .A0    (A0),
    .Di0   (Di0),
    .Do0   (Do0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare Do0 against the model, only on the bytes the model knows.
  task automatic check_model(input string tag);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (exp_kn[i]) m[8*i +: 8] = 8'hFF;
    if (exp_kn != 4'h0) check_eq(tag, Do0 & m, exp_do & m);
  endtask

  // One clock of traffic; outputs settle #1 after the rising edge.
  task automatic op(input logic en, input logic [3:0] we, input logic [6:0] a,
                    input logic [31:0] di);
    EN0 = en;
    WE0 = we;
    A0  = a;
    Di0 = di;
    @(posedge CLK);
    if (en) begin
      exp_do = ref_mem[a];
      exp_kn = ref_kn[a];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          ref_mem[a][8*i +: 8] = di[8*i +: 8];
          ref_kn[a][i]         = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic async_reset_pulse(input string tag);
    RST_N = 1'b0;
    #1;
    check_eq(tag, Do0, 32'h0);
    RST_N  = 1'b1;
    exp_do = 32'h0;
    exp_kn = 4'hF;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = '0;
      ref_kn[i]  = 4'h0;
    end
    exp_do = '0;
    exp_kn = 4'hF;
    RST_N  = 1'b0;
    EN0    = 1'b0;
    WE0    = '0;
    A0     = '0;
    Di0    = '0;

    // 1. Reset
    repeat (2) @(posedge CLK);
    #1 check_eq("reset_low", Do0, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    op(1'b0, 4'h0, 7'h00, 32'h0);
    check_eq("reset_released", Do0, 32'h0);

    // 2-4. Full-word and byte writes in bank 0 and bank 1
    for (int bk = 0; bk < 2; bk++) begin
      logic [6:0] base;
      base = 7'(bk * 16);
      op(1'b1, 4'hF, base + 7'd0, 32'hAA0055BB);
      op(1'b1, 4'hF, base + 7'd1, 32'hAA0055CC);
      op(1'b1, 4'hF, base + 7'd2, 32'hAA0055DD);
      op(1'b1, 4'h0, base + 7'd0, 32'h0);
      check_eq("word_rd0", Do0, 32'hAA0055BB);
      op(1'b1, 4'h1, base + 7'd2, 32'h00000033);
      op(1'b1, 4'h2, base + 7'd1, 32'h00003300);
      op(1'b1, 4'h4, base + 7'd0, 32'h00330000);
      op(1'b1, 4'h0, base + 7'd2, 32'h0);
      check_eq("byte_rd2", Do0, 32'hAA005533);
      op(1'b1, 4'h0, base + 7'd1, 32'h0);
      check_eq("byte_rd1", Do0, 32'hAA0033CC);
      op(1'b1, 4'h0, base + 7'd0, 32'h0);
      check_eq("byte_rd0", Do0, 32'hAA3355BB);
    end
    op(1'b1, 4'h0, 7'h00, 32'h0);
    check_eq("bank0_w0_kept", Do0, 32'hAA3355BB);
    op(1'b1, 4'h0, 7'h01, 32'h0);
    check_eq("bank0_w1_kept", Do0, 32'hAA0033CC);
    op(1'b1, 4'h0, 7'h02, 32'h0);
    check_eq("bank0_w2_kept", Do0, 32'hAA005533);

    // 5. Disabled port: no write, output holds
    op(1'b0, 4'hF, 7'h00, 32'hFFFFFFFF);
    check_eq("en0_hold", Do0, 32'hAA005533);
    op(1'b1, 4'h0, 7'h00, 32'h0);
    check_eq("en0_nowrite", Do0, 32'hAA3355BB);

    // 6. Read-during-write returns old data, new data on the next enabled edge
    op(1'b1, 4'hF, 7'h7F, 32'hDEADBEEF);
    op(1'b1, 4'hF, 7'h7F, 32'h12345678);
    check_eq("rdw_old", Do0, 32'hDEADBEEF);
    op(1'b1, 4'h0, 7'h7F, 32'h0);
    check_eq("rdw_new", Do0, 32'h12345678);

    // Async reset mid-operation clears Do0 but not the array
    async_reset_pulse("async_rst");
    op(1'b1, 4'h0, 7'h00, 32'h0);
    check_eq("array_survives_rst", Do0, 32'hAA3355BB);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        en;
      logic [3:0]  we;
      logic [6:0]  a;
      logic [31:0] di;
      en = ($urandom_range(0, 9) < 8);
      we = 4'($urandom_range(0, 15));
      a  = 7'($urandom_range(0, 127));
      di = $urandom;
      op(en, we, a, di);
      check_model("rand_rd");
      if ($urandom_range(0, 199) == 0) async_reset_pulse("rand_rst");
    end

    // Final sweep of every address
    for (int a = 0; a < 128; a++) begin
      op(1'b1, 4'h0, 7'(a), 32'h0);
      check_model("sweep_rd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
